modinv_invert_scheduler: RTL and testbench
==========================================

MODINV_INVERT_SCHEDULER -- requirements
Module: modinv_invert_scheduler

Interface
REQ-001 SHALL have parameter OPERAND_WIDTH, default 256: operand bit width; iteration limit K_MAX = 2*OPERAND_WIDTH.
REQ-002 SHALL have parameter K_BITS, default 10: width of iteration counter; K_BITS >= clog2(K_MAX+1).
REQ-003 SHALL have clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have ena, input, 1: start request, honoured only while rdy=1.
REQ-006 SHALL have rdy, output, 1: high when idle; results valid while high.
REQ-007 SHALL have cmp_ena, output, 1: start pulse to the compare helper.
REQ-008 SHALL have cmp_rdy, input, 1: compare helper idle/done.
REQ-009 SHALL have cmp_v_is_zero, cmp_u_is_even, cmp_v_is_even, cmp_u_gt_v, inputs, 1 each: compare flags, valid while cmp_rdy=1 after a compare.
REQ-010 SHALL have precalc_ena, output, 1: start pulse to the invert precalc helper.
REQ-011 SHALL have precalc_rdy, input, 1: precalc helper idle/done.
REQ-012 SHALL have update_ena, output, 1: start pulse to the update (copy-back) helper.
REQ-013 SHALL have update_rdy, input, 1: update helper idle/done.
REQ-014 SHALL have update_sel, output, 2: branch select to the update helper.
REQ-015 SHALL have k, output, K_BITS: almost-inverse iteration count.
REQ-016 SHALL have err, output, 1: iteration limit hit without v=0.

Function
REQ-017 SHALL implement a Moore FSM with states IDLE, CMP_START, CMP_WAIT, DECIDE, PRE_START, PRE_WAIT, UPD_START, UPD_WAIT.
REQ-018 SHALL drive rdy=1 only in IDLE; cmp_ena=1 only in CMP_START; precalc_ena=1 only in PRE_START; update_ena=1 only in UPD_START (single-cycle pulses).
REQ-019 IDLE: on ena=1, SHALL clear k and err and go to CMP_START; ena=0 stays IDLE; ena outside IDLE ignored.
REQ-020 START states SHALL last one cycle, then go to the matching WAIT state.
REQ-021 WAIT states SHALL hold until the matching helper rdy=1, sampled from the first WAIT cycle (helpers drop rdy the cycle after ena).
REQ-022 CMP_WAIT with cmp_rdy=1 SHALL go to DECIDE.
REQ-023 DECIDE: cmp_v_is_zero=1 -> IDLE, err=0; else k==K_MAX -> IDLE, err=1; else register update_sel, go to PRE_START.
REQ-024 update_sel priority: u even -> 0 (U_HALF); else v even -> 1 (V_HALF); else u_gt_v -> 2 (U_MINUS_V); else 3 (V_MINUS_U).
REQ-025 PRE_WAIT with precalc_rdy=1 SHALL go to UPD_START.
REQ-026 UPD_WAIT with update_rdy=1 SHALL increment k and go to CMP_START.
REQ-027 update_sel SHALL stay constant from DECIDE exit until next DECIDE.
REQ-028 k SHALL never exceed K_MAX; no wrap-around.
REQ-029 k, err, update_sel SHALL hold after return to IDLE until next accepted ena.
REQ-030 Flags SHALL be sampled only in DECIDE; changes elsewhere ignored.

Reset
REQ-031 rst=1 SHALL force IDLE, k=0, err=0, update_sel=0, all *_ena=0, rdy=1 on next edge, including mid-operation.
REQ-032 After rst deasserts, the first ena SHALL start a clean run; no pending pulse is reissued.

Verification
REQ-033 Stubs rdy 1 cycle after ena; ena at cycle 0, v_is_zero=1 first compare -> cmp_ena cycle 1, rdy=1 cycle 5, k=0, err=0, no precalc_ena/update_ena.
REQ-034 Flag sequence (u even),(v even),(odd,u>v),(odd,u<v),(v=0) -> update_sel 0,1,2,3 in order, four precalc/update pulse pairs, final k=4, err=0.
REQ-035 OPERAND_WIDTH=4, v_is_zero never set -> exactly 8 iterations, rdy=1 with k=8, err=1.
REQ-036 Helper stubs holding rdy low 20 cycles -> FSM stalls in WAIT, each ena stays single-cycle, no extra pulses.
REQ-037 rst in PRE_WAIT and UPD_WAIT -> next cycle rdy=1, k=0, all enables 0; ena pulses while busy -> no effect.

Source files
------------

// File: rtl/modinv_invert_scheduler_if.sv
// Handshake bundle between the inversion scheduler, its requester and its
// three helper engines (compare, precalc, update).
interface modinv_invert_scheduler_if #(
    parameter int K_BITS = 10
);
    logic              ena;
    logic              rdy;
    logic              cmp_ena;
    logic              cmp_rdy;
    logic              cmp_v_is_zero;
    logic              cmp_u_is_even;
    logic              cmp_v_is_even;
    logic              cmp_u_gt_v;
    logic              precalc_ena;
    logic              precalc_rdy;
    logic              update_ena;
    logic              update_rdy;
    logic [1:0]        update_sel;
    logic [K_BITS-1:0] k;
    logic              err;

    // Scheduler side.
    modport slave (
        input  ena, cmp_rdy, cmp_v_is_zero, cmp_u_is_even, cmp_v_is_even,
               cmp_u_gt_v, precalc_rdy, update_rdy,
        output rdy, cmp_ena, precalc_ena, update_ena, update_sel, k, err
    );

    // Requester and helper side.
    modport master (
        output ena, cmp_rdy, cmp_v_is_zero, cmp_u_is_even, cmp_v_is_even,
               cmp_u_gt_v, precalc_rdy, update_rdy,
        input  rdy, cmp_ena, precalc_ena, update_ena, update_sel, k, err
    );
endinterface

// File: rtl/modinv_invert_scheduler.sv
// Sequencer for the almost-inverse loop: compare, choose a branch, precalc,
// copy back, count iterations until v reaches zero or the limit is hit.
module modinv_invert_scheduler #(
    parameter int OPERAND_WIDTH = 256,
    parameter int K_BITS        = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    modinv_invert_scheduler_if.slave  bus
);
    localparam logic [K_BITS-1:0] K_MAX = K_BITS'(2 * OPERAND_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        CMP_START,
        CMP_WAIT,
        DECIDE,
        PRE_START,
        PRE_WAIT,
        UPD_START,
        UPD_WAIT
    } state_e;

    typedef enum logic [1:0] {
        U_HALF    = 2'd0,
        V_HALF    = 2'd1,
        U_MINUS_V = 2'd2,
        V_MINUS_U = 2'd3
    } sel_e;

    state_e            state_q, state_d;
    logic [K_BITS-1:0] k_q, k_d;
    logic              err_q, err_d;
    sel_e              sel_q, sel_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            err_q   <= 1'b0;
            sel_q   <= U_HALF;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            err_q   <= err_d;
            sel_q   <= sel_d;
        end
    end

    // NOTE: every output of this block is defaulted first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        err_d   = err_q;
        sel_d   = sel_q;

        unique case (state_q)
            IDLE: begin
                if (bus.ena) begin
                    k_d     = '0;
                    err_d   = 1'b0;
                    state_d = CMP_START;
                end
            end
            CMP_START: state_d = CMP_WAIT;
            CMP_WAIT: begin
                if (bus.cmp_rdy) state_d = DECIDE;
            end
            DECIDE: begin
                // Flags are only trusted here; branch select is frozen until the next compare.
                if (bus.cmp_v_is_zero) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end else if (k_q == K_MAX) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    if (bus.cmp_u_is_even)      sel_d = U_HALF;
                    else if (bus.cmp_v_is_even) sel_d = V_HALF;
                    else if (bus.cmp_u_gt_v)    sel_d = U_MINUS_V;
                    else                        sel_d = V_MINUS_U;
                    state_d = PRE_START;
                end
            end
            PRE_START: state_d = PRE_WAIT;
            PRE_WAIT: begin
                if (bus.precalc_rdy) state_d = UPD_START;
            end
            UPD_START: state_d = UPD_WAIT;
            UPD_WAIT: begin
                if (bus.update_rdy) begin
                    if (k_q != K_MAX) k_d = k_q + 1'b1;
                    state_d = CMP_START;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rdy         = (state_q == IDLE);
    assign bus.cmp_ena     = (state_q == CMP_START);
    assign bus.precalc_ena = (state_q == PRE_START);
    assign bus.update_ena  = (state_q == UPD_START);
    assign bus.update_sel  = sel_q;
    assign bus.k           = k_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_modinv_invert_scheduler.sv
// Randomized bench for the inversion scheduler: helper stubs with variable
// latency, a flag script per run and a loop-level reference model.
module tb_modinv_invert_scheduler;
    localparam int OPERAND_WIDTH = 4;
    localparam int K_BITS        = 4;
    localparam int K_MAX         = 2 * OPERAND_WIDTH;
    localparam int BUDGET        = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    modinv_invert_scheduler_if #(.K_BITS(K_BITS)) bus ();

    modinv_invert_scheduler #(
        .OPERAND_WIDTH(OPERAND_WIDTH),
        .K_BITS       (K_BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Environment state shared between the helper stubs and the run tasks.
    int         cyc_now = 0;
    int         run_start = 0;
    int         n_cmp = 0, n_pre = 0, n_upd = 0;
    int         pulse_err = 0;
    int         first_cmp = -1;
    int         stall_lat = 0;
    int         cmp_cnt = 0, pre_cnt = 0, upd_cnt = 0;
    bit         prev_c = 0, prev_p = 0, prev_u = 0;
    logic [1:0] sel_seen[$];
    logic [3:0] flag_q[$];      // {v_is_zero, u_is_even, v_is_even, u_gt_v}
    logic [1:0] sel_hold = 2'd0;

    always @(posedge clk) cyc_now <= cyc_now + 1;

    function automatic int pick_lat();
        return (stall_lat > 0) ? stall_lat : int'($urandom_range(1, 3));
    endfunction

    task automatic drive_flags(input logic [3:0] f);
        bus.cmp_v_is_zero = f[3];
        bus.cmp_u_is_even = f[2];
        bus.cmp_v_is_even = f[1];
        bus.cmp_u_gt_v    = f[0];
    endtask

    // Helper stubs: rdy drops the cycle after ena and rises after the latency.
    // Flags are garbage while a compare or precalc is in flight.
    always @(negedge clk) begin
        if (rst) begin
            cmp_cnt = 0; pre_cnt = 0; upd_cnt = 0;
            bus.cmp_rdy = 1'b1; bus.precalc_rdy = 1'b1; bus.update_rdy = 1'b1;
            prev_c = 0; prev_p = 0; prev_u = 0;
        end else begin
            if (bus.cmp_ena) begin
                n_cmp++;
                if (prev_c) pulse_err++;
                if (n_cmp == 1) first_cmp = cyc_now - run_start;
                bus.cmp_rdy = 1'b0;
                cmp_cnt = pick_lat() + 1;
                drive_flags(4'($urandom));
            end else if (cmp_cnt > 0) begin
                cmp_cnt--;
                if (cmp_cnt == 0) begin
                    bus.cmp_rdy = 1'b1;
                    drive_flags(flag_q.size() > 0 ? flag_q.pop_front() : 4'b0001);
                end
            end
            if (bus.precalc_ena) begin
                n_pre++;
                if (prev_p) pulse_err++;
                bus.precalc_rdy = 1'b0;
                pre_cnt = pick_lat() + 1;
                drive_flags(4'($urandom));
            end else if (pre_cnt > 0) begin
                pre_cnt--;
                if (pre_cnt == 0) bus.precalc_rdy = 1'b1;
            end
            if (bus.update_ena) begin
                n_upd++;
                if (prev_u) pulse_err++;
                sel_seen.push_back(bus.update_sel);
                bus.update_rdy = 1'b0;
                upd_cnt = pick_lat() + 1;
            end else if (upd_cnt > 0) begin
                upd_cnt--;
                if (upd_cnt == 0) bus.update_rdy = 1'b1;
            end
            prev_c = bus.cmp_ena;
            prev_p = bus.precalc_ena;
            prev_u = bus.update_ena;
        end
    end

    // Loop-level model of the almost-inverse iteration.
    task automatic model(input logic [3:0] fl[$], input logic [1:0] prev_sel,
                         output int iters, output bit e,
                         output logic [1:0] sels[$], output logic [1:0] fin);
        logic [1:0] s;
        iters = 0; e = 1'b0; fin = prev_sel;
        sels.delete();
        for (int i = 0; i < fl.size(); i++) begin
            if (fl[i][3]) break;
            if (iters == K_MAX) begin
                e = 1'b1;
                break;
            end
            if (fl[i][2])      s = 2'd0;
            else if (fl[i][1]) s = 2'd1;
            else if (fl[i][0]) s = 2'd2;
            else               s = 2'd3;
            sels.push_back(s);
            fin = s;
            iters++;
        end
    endtask

    function automatic logic [3:0] rand_flags(input bit allow_zero);
        logic [3:0] f;
        f = 4'($urandom);
        f[3] = allow_zero && ($urandom_range(0, 4) == 0);
        return f;
    endfunction

    task automatic fill_flags(input bit allow_zero);
        flag_q.delete();
        for (int i = 0; i <= K_MAX; i++) flag_q.push_back(rand_flags(allow_zero));
    endtask

    task automatic clear_counts();
        n_cmp = 0; n_pre = 0; n_upd = 0; first_cmp = -1;
        sel_seen.delete();
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        sel_hold = 2'd0;
    endtask

    int last_done = 0;

    task automatic do_run(input string tag, input bit noise);
        int         n;
        int         exp_iters;
        bit         exp_err;
        logic [1:0] exp_sels[$];
        logic [1:0] exp_fin;
        model(flag_q, sel_hold, exp_iters, exp_err, exp_sels, exp_fin);
        @(negedge clk);
        clear_counts();
        run_start = cyc_now;
        bus.ena = 1'b1;
        @(negedge clk);
        bus.ena = 1'b0;
        n = 1;
        while (!bus.rdy && n < BUDGET) begin
            if (noise) bus.ena = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        bus.ena = 1'b0;
        last_done = n;
        check({tag, "_done"}, bus.rdy, 1);
        if (!bus.rdy) begin
            pulse_reset();
            return;
        end
        check({tag, "_k"}, bus.k, exp_iters);
        check({tag, "_err"}, bus.err, exp_err);
        check({tag, "_sel"}, bus.update_sel, exp_fin);
        check({tag, "_ncmp"}, n_cmp, exp_iters + 1);
        check({tag, "_npre"}, n_pre, exp_iters);
        check({tag, "_nupd"}, n_upd, exp_iters);
        check({tag, "_pulse"}, pulse_err, 0);
        check({tag, "_nsel"}, sel_seen.size(), exp_sels.size());
        for (int i = 0; i < exp_sels.size() && i < sel_seen.size(); i++)
            check({tag, "_seq"}, sel_seen[i], exp_sels[i]);
        sel_hold = exp_fin;
        repeat (2) @(negedge clk);
        check({tag, "_khold"}, bus.k, exp_iters);
        check({tag, "_errhold"}, bus.err, exp_err);
    endtask

    task automatic reset_mid(input string tag, input bit in_upd);
        int n;
        fill_flags(0);
        stall_lat = 20;
        @(negedge clk);
        clear_counts();
        run_start = cyc_now;
        bus.ena = 1'b1;
        @(negedge clk);
        bus.ena = 1'b0;
        n = 0;
        while (((in_upd ? n_upd : n_pre) < 2) && n < BUDGET) begin
            bus.ena = !bus.rdy && ($urandom_range(0, 1) == 1);
            @(negedge clk);
            n++;
        end
        bus.ena = 1'b0;
        check({tag, "_reached"}, n < BUDGET, 1);
        repeat (3) @(negedge clk);
        check({tag, "_kbefore"}, bus.k, 1);
        check({tag, "_busy"}, bus.rdy, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        check({tag, "_rdy"}, bus.rdy, 1);
        check({tag, "_k"}, bus.k, 0);
        check({tag, "_err"}, bus.err, 0);
        check({tag, "_sel"}, bus.update_sel, 0);
        check({tag, "_enas"}, {bus.cmp_ena, bus.precalc_ena, bus.update_ena}, 0);
        rst = 1'b0;
        sel_hold = 2'd0;
        stall_lat = 0;
        clear_counts();
        repeat (5) @(negedge clk);
        check({tag, "_nopulse"}, n_cmp + n_pre + n_upd, 0);
    endtask

    initial begin
        bus.ena = 1'b0;
        bus.cmp_rdy = 1'b1; bus.precalc_rdy = 1'b1; bus.update_rdy = 1'b1;
        drive_flags(4'b0000);
        repeat (3) @(negedge clk);
        check("rst_rdy", bus.rdy, 1);
        check("rst_k", bus.k, 0);
        check("rst_err", bus.err, 0);
        check("rst_sel", bus.update_sel, 0);
        check("rst_enas", {bus.cmp_ena, bus.precalc_ena, bus.update_ena}, 0);
        rst = 1'b0;

        stall_lat = 1;
        flag_q = '{4'b1000};
        do_run("vz_first", 0);
        check("vz_first_cmp_cycle", first_cmp, 1);
        check("vz_first_rdy_cycle", last_done, 5);

        flag_q = '{4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b1000};
        do_run("branches", 0);
        check("branches_k4", bus.k, 4);

        fill_flags(0);
        do_run("limit", 0);
        check("limit_k8", bus.k, K_MAX);
        check("limit_err1", bus.err, 1);

        stall_lat = 20;
        fill_flags(1);
        do_run("stall", 1);
        stall_lat = 0;

        for (int r = 0; r < 25; r++) begin
            fill_flags(1);
            do_run("rand", 1);
        end

        reset_mid("rst_pre", 0);
        fill_flags(1);
        do_run("after_rst_pre", 0);

        reset_mid("rst_upd", 1);
        fill_flags(1);
        do_run("after_rst_upd", 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
